// File: rtl/led_pkg.sv
// Shared encodings for the multi-channel LED blinker: mode values and
// per-channel FSM state codes.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ON_ENC    = 3'd1;
  localparam logic [2:0] ST_OFF_ENC   = 3'd2;
  localparam logic [2:0] ST_GAP_ENC   = 3'd3;
  localparam logic [2:0] ST_SOLID_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ON_PH = ST_ON_ENC,
    ST_OFF_PH = ST_OFF_ENC,
    ST_GAP_PH = ST_GAP_ENC,
    ST_SOLID = ST_SOLID_ENC
  } state_e;

endpackage

// File: rtl/led_blinker_chan.sv
// One LED channel: mode-change/sync restart, phase timer, burst pulse counter,
// registered LED and end-of-burst pulse.
module led_blinker_chan
  import led_pkg::*;
#(
  parameter int TW = 11,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          sync_i,
  input  logic [1:0]    mode_i,
  input  logic [TW-1:0] on_i,
  input  logic [TW-1:0] off_i,
  input  logic [TW-1:0] gap_i,
  input  logic [CW-1:0] cnt_i,
  output logic          led_o,
  output logic          burst_end_o
);

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] pcnt_q;
  logic [1:0]    mode_q;
  logic          led_q;
  logic          burst_end_q;
  logic          restart;
  logic          phase_end;

  assign restart   = (mode_i != mode_q) || sync_i;
  assign phase_end = tick_i && (timer_q == '0);

  // Restart has priority over any phase boundary in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pcnt_q      <= '0;
      mode_q      <= MODE_OFF;
      led_q       <= 1'b0;
      burst_end_q <= 1'b0;
    end else begin
      mode_q      <= mode_i;
      burst_end_q <= 1'b0;
      if (restart) begin
        pcnt_q <= '0;
        unique case (mode_i)
          MODE_OFF: begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
          end
          MODE_ON: begin
            state_q <= ST_SOLID;
            timer_q <= '0;
            led_q   <= 1'b1;
          end
          default: begin
            state_q <= ST_ON_PH;
            timer_q <= on_i;
            led_q   <= 1'b1;
          end
        endcase
      end else begin
        unique case (state_q)
          ST_ON_PH: begin
            if (phase_end) begin
              led_q <= 1'b0;
              if ((mode_q == MODE_BURST) && (pcnt_q == cnt_i)) begin
                state_q <= ST_GAP_PH;
                timer_q <= gap_i;
              end else begin
                if (mode_q == MODE_BURST) pcnt_q <= pcnt_q + CW'(1);
                state_q <= ST_OFF_PH;
                timer_q <= off_i;
              end
            end else if (tick_i) begin
              timer_q <= timer_q - TW'(1);
            end
          end
          ST_OFF_PH: begin
            if (phase_end) begin
              state_q <= ST_ON_PH;
              timer_q <= on_i;
              led_q   <= 1'b1;
            end else if (tick_i) begin
              timer_q <= timer_q - TW'(1);
            end
          end
          ST_GAP_PH: begin
            if (phase_end) begin
              state_q     <= ST_ON_PH;
              timer_q     <= on_i;
              pcnt_q      <= '0;
              led_q       <= 1'b1;
              burst_end_q <= 1'b1;
            end else if (tick_i) begin
              timer_q <= timer_q - TW'(1);
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign led_o       = led_q;
  assign burst_end_o = burst_end_q;

endmodule

// File: rtl/led_blinker_multi.sv
// NCH-channel LED blinker: one shared tick prescaler with sync restart,
// feeding an independent FSM per channel.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW  = 15,
  parameter int TW  = 11,
  parameter int CW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [NCH-1:0]    led,
  input  logic [2*NCH-1:0]  mode,
  input  logic [TW*NCH-1:0] on,
  input  logic [TW*NCH-1:0] off,
  input  logic [TW*NCH-1:0] gap,
  input  logic [CW*NCH-1:0] cnt,
  input  logic              sync,
  output logic [NCH-1:0]    burst_end
);

  localparam logic [DW:0] PS_MAX = {1'b1, {DW{1'b0}}};

  logic [DW:0] ps_q;
  logic [DW:0] ps_d;
  logic        tick;

  // sync suppresses the tick so the first phase after it is a full value+1 ticks.
  assign tick = (ps_q == PS_MAX) && !sync;

  always_comb begin
    ps_d = ps_q + (DW+1)'(1);
    if (sync || (ps_q == PS_MAX)) ps_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_blinker_chan #(
      .TW(TW),
      .CW(CW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick),
      .sync_i     (sync),
      .mode_i     (mode[2*i +: 2]),
      .on_i       (on[TW*i +: TW]),
      .off_i      (off[TW*i +: TW]),
      .gap_i      (gap[TW*i +: TW]),
      .cnt_i      (cnt[CW*i +: CW]),
      .led_o      (led[i]),
      .burst_end_o(burst_end[i])
    );
  end

endmodule
